// File: rtl/mac_tile_ms_pkg.sv
// rtl/mac_tile_ms_pkg.sv - shared state encoding and instruction bit positions for the MAC tile
package mac_tile_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WS_LOAD = 2'd1,
        WS_EXEC = 2'd2,
        OS_EXEC = 2'd3
    } state_t;

    localparam int LOAD  = 0;
    localparam int EXEC  = 1;
    localparam int FLUSH = 2;

endpackage

// File: rtl/mac_tile_ms_mac_sat.sv
// rtl/mac_tile_ms_mac_sat.sv - combinational c + a*w with optional saturation
module mac_sat #(
    parameter int bw      = 4,
    parameter int psum_bw = 16,
    parameter int sat     = 0
) (
    input  logic [bw-1:0]      a_i,
    input  logic [bw-1:0]      w_i,
    input  logic [psum_bw-1:0] c_i,
    output logic [psum_bw-1:0] y_o
);

    localparam int pw = 2 * bw + 1;

    logic signed [pw-1:0]  a_ext;
    logic signed [pw-1:0]  w_ext;
    logic signed [pw-1:0]  prod;
    logic [psum_bw-1:0]    p_ext;
    logic [psum_bw:0]      sum;
    logic                  ovf;

    // a is unsigned, w is signed: zero- and sign-extend before the multiply
    assign a_ext = $signed({{(pw - bw){1'b0}}, a_i});
    assign w_ext = $signed({{(pw - bw){w_i[bw-1]}}, w_i});
    assign prod  = a_ext * w_ext;

    generate
        if (psum_bw > pw) begin : g_ext
            assign p_ext = {{(psum_bw - pw){prod[pw-1]}}, prod};
        end else if (psum_bw == pw) begin : g_eq
            assign p_ext = prod;
        end else begin : g_trunc
            assign p_ext = prod[psum_bw-1:0];
        end
    endgenerate

    assign sum = {c_i[psum_bw-1], c_i} + {p_ext[psum_bw-1], p_ext};
    assign ovf = (sat != 0) && (sum[psum_bw] != sum[psum_bw-1]);

    always_comb begin
        y_o = sum[psum_bw-1:0];
        if (ovf) begin
            y_o = sum[psum_bw] ? {1'b1, {(psum_bw - 1){1'b0}}}
                               : {1'b0, {(psum_bw - 1){1'b1}}};
        end
    end

endmodule

// File: rtl/mac_tile_ms.sv
// rtl/mac_tile_ms.sv - systolic MAC tile supporting weight- and output-stationary dataflow
module mac_tile_ms
    import mac_tile_pkg::*;
#(
    parameter int bw      = 4,
    parameter int psum_bw = 16,
    parameter int nw      = 2,
    parameter int sat     = 0
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [bw-1:0]                        in_w,
    input  logic [psum_bw-1:0]                   in_n,
    input  logic [2:0]                           inst_w,
    input  logic                                 mode,
    input  logic [((nw > 1) ? $clog2(nw) : 1)-1:0] wsel,
    output logic [psum_bw-1:0]                   out_s,
    output logic                                 out_s_valid,
    output logic [bw-1:0]                        out_e,
    output logic [2:0]                           inst_e
);

    localparam int ptr_w = $clog2(nw + 1);
    localparam logic [ptr_w-1:0] nw_p = ptr_w'(nw);

    state_t             state_q;
    logic [ptr_w-1:0]   ptr_q;
    logic [bw-1:0]      slot_q [nw];
    logic [psum_bw-1:0] acc_q;
    logic [psum_bw-1:0] out_s_q;
    logic               out_s_valid_q;
    logic [bw-1:0]      out_e_q;
    logic [2:0]         inst_e_q;

    logic               load, exec, flush;
    logic               os_path, capture;
    logic [bw-1:0]      w_sel, mac_w;
    logic [psum_bw-1:0] mac_c, mac_y, w_zx;

    assign load  = inst_w[LOAD];
    assign exec  = inst_w[EXEC];
    assign flush = inst_w[FLUSH];

    always_comb begin
        w_sel = slot_q[0];
        for (int i = 1; i < nw; i++) begin
            if (32'(wsel) == i) w_sel = slot_q[i];
        end
    end

    // One multiplier: OS takes the weight from the north and accumulates locally
    assign os_path = (state_q == OS_EXEC) || (state_q == IDLE && !mode);
    assign mac_w   = os_path ? in_n[bw-1:0] : w_sel;
    assign mac_c   = os_path ? acc_q : in_n;
    assign w_zx    = {{(psum_bw - bw){1'b0}}, in_n[bw-1:0]};

    assign capture = load && !flush && (ptr_q < nw_p) &&
                     ((state_q == IDLE && mode) || state_q == WS_LOAD);

    mac_sat #(.bw(bw), .psum_bw(psum_bw), .sat(sat)) u_mac (
        .a_i (in_w),
        .w_i (mac_w),
        .c_i (mac_c),
        .y_o (mac_y)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            acc_q         <= '0;
            out_s_q       <= '0;
            out_s_valid_q <= 1'b0;
            out_e_q       <= '0;
            inst_e_q      <= '0;
            for (int i = 0; i < nw; i++) slot_q[i] <= '0;
        end else begin
            out_e_q       <= in_w;
            inst_e_q      <= inst_w;
            out_s_valid_q <= 1'b0;
            // Captured loads are consumed here; overflow loads travel east
            if (capture) begin
                for (int i = 0; i < nw; i++) begin
                    if (ptr_q == ptr_w'(i)) slot_q[i] <= in_w;
                end
                ptr_q          <= ptr_q + 1'b1;
                inst_e_q[LOAD] <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (!flush) begin
                        if (mode && load) begin
                            state_q <= exec ? WS_EXEC : WS_LOAD;
                            if (exec) begin
                                out_s_q       <= mac_y;
                                out_s_valid_q <= 1'b1;
                            end
                        end else if (!mode && exec) begin
                            acc_q   <= mac_y;
                            out_s_q <= w_zx;
                            state_q <= OS_EXEC;
                        end
                    end
                end
                WS_LOAD, WS_EXEC: begin
                    if (flush) begin
                        for (int i = 0; i < nw; i++) slot_q[i] <= '0;
                        ptr_q   <= '0;
                        state_q <= IDLE;
                    end else if (exec) begin
                        out_s_q       <= mac_y;
                        out_s_valid_q <= 1'b1;
                        state_q       <= WS_EXEC;
                    end
                end
                OS_EXEC: begin
                    if (flush) begin
                        out_s_q       <= acc_q;
                        out_s_valid_q <= 1'b1;
                        acc_q         <= '0;
                        state_q       <= IDLE;
                    end else if (exec) begin
                        acc_q   <= mac_y;
                        out_s_q <= w_zx;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_s       = out_s_q;
    assign out_s_valid = out_s_valid_q;
    assign out_e       = out_e_q;
    assign inst_e      = inst_e_q;

endmodule

// File: tb/tb_mac_tile_ms.sv
// tb/tb_mac_tile_ms.sv - scoreboard bench for mac_tile_ms in WS, OS and saturation cases
module tb_mac_tile_ms;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  in_w;
    logic [15:0] in_n;
    logic [2:0]  inst_w;
    logic        mode;
    logic [0:0]  wsel;
    logic [15:0] out_s;
    logic        out_s_valid;
    logic [3:0]  out_e;
    logic [2:0]  inst_e;

    logic [3:0]  s_in_w;
    logic [7:0]  s_in_n;
    logic [2:0]  s_inst;
    logic        s_mode;
    logic [0:0]  s_wsel;
    logic [7:0]  y1, y0;
    logic        v1, v0;
    logic [3:0]  e1, e0;
    logic [2:0]  ie1, ie0;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    mac_tile_ms dut (
        .clk(clk), .reset(reset), .in_w(in_w), .in_n(in_n), .inst_w(inst_w),
        .mode(mode), .wsel(wsel), .out_s(out_s), .out_s_valid(out_s_valid),
        .out_e(out_e), .inst_e(inst_e)
    );

    mac_tile_ms #(.psum_bw(8), .sat(1)) dut_s1 (
        .clk(clk), .reset(reset), .in_w(s_in_w), .in_n(s_in_n), .inst_w(s_inst),
        .mode(s_mode), .wsel(s_wsel), .out_s(y1), .out_s_valid(v1),
        .out_e(e1), .inst_e(ie1)
    );

    mac_tile_ms #(.psum_bw(8), .sat(0)) dut_s0 (
        .clk(clk), .reset(reset), .in_w(s_in_w), .in_n(s_in_n), .inst_w(s_inst),
        .mode(s_mode), .wsel(s_wsel), .out_s(y0), .out_s_valid(v0),
        .out_e(e0), .inst_e(ie0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic [2:0] i, input logic [3:0] w, input logic [15:0] n,
                        input logic m, input logic s);
        @(negedge clk);
        inst_w = i; in_w = w; in_n = n; mode = m; wsel = s;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every valid psum must match the oldest expected entry
    always @(posedge clk) begin
        #1;
        if (out_s_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: got out_s=%0h with no expected result", out_s);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (out_s !== e) begin
                    errors++;
                    $display("FAIL psum: got %0h expected %0h", out_s, e);
                end
            end
        end
    end

    initial begin
        reset = 1'b0;
        inst_w = 3'b000; in_w = 4'd0; in_n = 16'd0; mode = 1'b0; wsel = 1'b0;
        s_inst = 3'b000; s_in_w = 4'd0; s_in_n = 8'd0; s_mode = 1'b0; s_wsel = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_s", 32'(out_s), 32'd0);
        chk("rst_valid", 32'(out_s_valid), 32'd0);
        chk("rst_out_e", 32'(out_e), 32'd0);
        chk("rst_inst_e", 32'(inst_e), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // WS load 3,5 then overflow load 7
        step(3'b001, 4'd3, 16'd0, 1'b1, 1'b0);
        chk("ld_captured_inst_e", 32'(inst_e), 32'd0);
        step(3'b001, 4'd5, 16'd0, 1'b1, 1'b0);
        step(3'b001, 4'd7, 16'd0, 1'b1, 1'b0);
        chk("ovf_out_e", 32'(out_e), 32'd7);
        chk("ovf_inst_e", 32'(inst_e), 32'd1);

        exp_q.push_back(16'd20);
        step(3'b010, 4'd2, 16'd10, 1'b1, 1'b1);
        exp_q.push_back(16'd3);
        step(3'b010, 4'd1, 16'd0, 1'b1, 1'b0);
        step(3'b000, 4'd0, 16'd0, 1'b1, 1'b0);

        // Flush WS, reload with a negative weight in slot 0
        step(3'b100, 4'd0, 16'd0, 1'b1, 1'b0);
        step(3'b001, 4'd8, 16'd0, 1'b1, 1'b0);
        step(3'b001, 4'd5, 16'd0, 1'b1, 1'b0);
        exp_q.push_back(16'hFFFA);
        step(3'b010, 4'd2, 16'd10, 1'b1, 1'b0);
        step(3'b100, 4'd0, 16'd0, 1'b1, 1'b0);
        step(3'b000, 4'd0, 16'd0, 1'b0, 1'b0);

        // OS accumulate 4 x (3*2), with a stray load and mode toggle mid-run
        step(3'b010, 4'd3, 16'd2, 1'b0, 1'b0);
        chk("os_fwd_weight", 32'(out_s), 32'd2);
        chk("os_no_valid", 32'(out_s_valid), 32'd0);
        step(3'b010, 4'd3, 16'd2, 1'b0, 1'b0);
        step(3'b001, 4'd9, 16'd0, 1'b1, 1'b0);
        chk("os_load_ignored", 32'(inst_e), 32'd1);
        step(3'b010, 4'd3, 16'd2, 1'b0, 1'b0);
        step(3'b010, 4'd3, 16'd2, 1'b0, 1'b0);
        exp_q.push_back(16'd24);
        step(3'b100, 4'd0, 16'd0, 1'b0, 1'b0);
        step(3'b100, 4'd0, 16'd0, 1'b0, 1'b0);
        step(3'b010, 4'd1, 16'd5, 1'b0, 1'b0);
        exp_q.push_back(16'd5);
        step(3'b100, 4'd0, 16'd0, 1'b0, 1'b0);

        // Reset in the middle of an OS accumulation
        step(3'b010, 4'd3, 16'd3, 1'b0, 1'b0);
        @(negedge clk);
        inst_w = 3'b000; in_w = 4'd0; in_n = 16'd0;
        reset = 1'b0;
        #1;
        chk("mid_rst_out_s", 32'(out_s), 32'd0);
        chk("mid_rst_valid", 32'(out_s_valid), 32'd0);
        chk("mid_rst_out_e", 32'(out_e), 32'd0);
        chk("mid_rst_inst_e", 32'(inst_e), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        step(3'b100, 4'd0, 16'd0, 1'b0, 1'b0);
        chk("post_rst_flush_out_s", 32'(out_s), 32'd0);
        step(3'b000, 4'd0, 16'd0, 1'b0, 1'b0);

        // Saturating vs wrapping accumulation at psum_bw=8
        @(negedge clk);
        s_inst = 3'b001; s_in_w = 4'd7; s_mode = 1'b1;
        @(negedge clk);
        s_inst = 3'b010; s_in_w = 4'd15; s_in_n = 8'd120; s_wsel = 1'b0;
        @(posedge clk);
        #1;
        chk("sat1_out_s", 32'(y1), 32'h7F);
        chk("sat1_valid", 32'(v1), 32'd1);
        chk("sat0_out_s", 32'(y0), 32'hE1);
        chk("sat0_valid", 32'(v0), 32'd1);
        @(negedge clk);
        s_inst = 3'b000;

        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_tile_ms.md
MAC_TILE_MS -- requirements
Module: mac_tile_ms

Interface
REQ-001 Parameter bw, default 4: activation and weight width.
REQ-002 Parameter psum_bw, default 16: partial-sum and accumulator width.
REQ-003 Parameter nw, default 2: number of weight slots held in WS mode; must be >= 1.
REQ-004 Parameter sat, default 0: 1 selects saturating accumulation, 0 selects two's-complement wrap.
REQ-005 The block SHALL have one clock. Reset is asynchronous and active-low.
REQ-006 clk  input  1  clock; all state updates on the rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 in_w  input  bw  activation (exec) or weight (load) from the west.
REQ-009 in_n  input  psum_bw  psum from the north (WS); bits [bw-1:0] carry the weight (OS).
REQ-010 inst_w  input  3  instruction: [0] load, [1] exec, [2] flush.
REQ-011 mode  input  1  1 = weight stationary (WS), 0 = output stationary (OS); sampled only in IDLE.
REQ-012 wsel  input  max(1,$clog2(nw))  WS weight-slot select for exec.
REQ-013 out_s  output  psum_bw  WS: psum; OS: weight forwarded south, or the accumulator on flush.
REQ-014 out_s_valid  output  1  out_s carries a psum (WS exec result or OS flush).
REQ-015 out_e  output  bw  registered in_w forwarded east.
REQ-016 inst_e  output  3  registered instruction forwarded east.

Function
REQ-017 The FSM states SHALL be IDLE, WS_LOAD, WS_EXEC and OS_EXEC.
REQ-018 IDLE SHALL go to WS_LOAD on load with mode=1, and to OS_EXEC on exec with mode=0.
  - Any other instruction in IDLE has no effect beyond east forwarding.
REQ-019 WS_LOAD SHALL write in_w to slot ptr and increment ptr, for each load while ptr<nw.
REQ-020 Loads arriving with ptr=nw SHALL NOT be captured.
  - They are forwarded east with inst_e[0]=1.
  - Captured loads SHALL leave inst_e[0]=0.
REQ-021 WS_LOAD SHALL go to WS_EXEC on exec.
  - Load and exec in the same cycle: the load is handled first, then the state moves.
REQ-022 WS exec SHALL register a=in_w, c=in_n and w=slot[wsel].
  - out_s = c + a*w SHALL appear on the cycle after sampling, with out_s_valid=1.
  - wsel >= nw SHALL select slot 0.
REQ-023 In OS_EXEC, exec SHALL accumulate acc += in_w*in_n[bw-1:0].
  - out_s SHALL present the weight, zero-extended, on the next cycle, with out_s_valid=0.
REQ-024 Flush SHALL have priority over load and exec in every state.
  - OS: out_s=acc and out_s_valid=1 on the next cycle; acc cleared; go to IDLE.
  - WS: all slots cleared, ptr=0; go to IDLE.
  - Flush in IDLE: no-op.
REQ-025 Arithmetic:
  - in_w unsigned; weight signed bw-bit.
  - Product sign-extended to psum_bw.
  - sat=1 clamps to [-2^(psum_bw-1), 2^(psum_bw-1)-1]; sat=0 wraps.
REQ-026 out_e and inst_e SHALL be in_w and inst_w delayed exactly one cycle in all states.
  - Exception: inst_e[0] masking per REQ-020.
REQ-027 A mode change outside IDLE SHALL be ignored.
REQ-028 out_s_valid SHALL be 0 in every cycle not covered by REQ-022 or REQ-024.

Reset
REQ-029 While reset=0, the block SHALL asynchronously clear:
  - state to IDLE; ptr, all slots and acc to 0;
  - out_s, out_s_valid, out_e and inst_e to 0.
REQ-030 Reset asserted mid-operation SHALL discard in-flight results; no valid output SHALL follow release.

Structure
REQ-031 Package mac_tile_pkg SHALL hold:
  - the FSM state enum;
  - the inst bit indices LOAD=0, EXEC=1, FLUSH=2.
REQ-032 Sub-module mac_sat SHALL hold the combinational multiply-add with the sat parameter.
  - It SHALL be instantiated once and shared by WS and OS.

Verification
REQ-033 WS load 3,5 (nw=2), then load 7 -> slots {3,5}; 7 appears on out_e with inst_e[0]=1 the cycle after.
REQ-034 WS exec in_w=2, wsel=1, in_n=10 -> out_s=20, out_s_valid=1 one cycle later; wsel=0 with weight -8 (0x8) -> out_s=-6.
REQ-035 OS exec 4 cycles of in_w=3, in_n[3:0]=2, then flush -> out_s=24, out_s_valid=1; acc=0; state IDLE.
REQ-036 sat=1, psum_bw=8, in_n=120, in_w=15, weight=7 -> out_s=127; sat=0 -> out_s=-31.
REQ-037 Reset asserted during OS accumulate (acc=9), then released, then flush -> no valid output; state IDLE; all outputs 0.
